// File: rtl/fpga_dff_er.sv
// WIDTH-bit D flip-flop with clock enable and synchronous active-high reset.
// Optional synchronous set input enabled by defining FPGA_DFFER_SET_EN.
module fpga_dff_er #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             reset_i,
`ifdef FPGA_DFFER_SET_EN
    input  logic             set_i,
`endif
    input  logic             E_i,
    input  logic [WIDTH-1:0] D_i,
    output logic [WIDTH-1:0] Q_o
);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("fpga_dff_er: WIDTH must be at least 1");
        end
    endgenerate

    // Ternary on E_i keeps an unknown enable visible as X on Q_o in simulation.
    always_ff @(posedge clk_i) begin
        if (reset_i)
            Q_o <= RESET_VAL;
`ifdef FPGA_DFFER_SET_EN
        else if (set_i)
            Q_o <= '1;
`endif
        else
            Q_o <= E_i ? D_i : Q_o;
    end

endmodule

// File: tb/tb_fpga_dff_er.sv
// Directed bench for fpga_dff_er: a 1-bit instance and an 8-bit instance (RESET_VAL=8'hA5).
module tb_fpga_dff_er;

    logic       clk = 1'b0;
    logic       rst1 = 1'b0, e1 = 1'b0, d1 = 1'b0;
    logic       q1;
    logic       rst8 = 1'b0, e8 = 1'b0;
    logic [7:0] d8 = 8'h00;
    logic [7:0] q8;
    logic       set1 = 1'b0, set8 = 1'b0;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    fpga_dff_er #(.WIDTH(1)) u_w1 (
        .clk_i   (clk),
        .reset_i (rst1),
`ifdef FPGA_DFFER_SET_EN
        .set_i   (set1),
`endif
        .E_i     (e1),
        .D_i     (d1),
        .Q_o     (q1)
    );

    fpga_dff_er #(.WIDTH(8), .RESET_VAL(8'hA5)) u_w8 (
        .clk_i   (clk),
        .reset_i (rst8),
`ifdef FPGA_DFFER_SET_EN
        .set_i   (set8),
`endif
        .E_i     (e8),
        .D_i     (d8),
        .Q_o     (q8)
    );

    // Sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic exp);
        total++;
        assert (q1 === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, q1, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] exp);
        total++;
        assert (q8 === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, q8, exp);
        end
    endtask

    initial begin
        // ---- WIDTH=1 ----
        rst1 = 1'b1; step();
        chk1("w1_reset", 1'b0);

        rst1 = 1'b0; e1 = 1'b1; d1 = 1'b1;
        #2 chk1("w1_no_comb_path", 1'b0);
        step();
        chk1("w1_load1", 1'b1);

        d1 = 1'b0; step();
        chk1("w1_load0", 1'b0);

        e1 = 1'b0; d1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk1("w1_hold0", 1'b0);
        end

        e1 = 1'b1; d1 = 1'b1; step();
        chk1("w1_reload1", 1'b1);
        e1 = 1'b0; d1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk1("w1_hold1", 1'b1);
        end

        // reset pulse entirely between edges must be ignored
        rst1 = 1'b1; #2 rst1 = 1'b0;
        step();
        chk1("w1_midcycle_rst", 1'b1);

        rst1 = 1'b1; e1 = 1'b1; d1 = 1'b1; step();
        chk1("w1_rst_priority", 1'b0);
        rst1 = 1'b0; e1 = 1'b0;

        // ---- WIDTH=8, RESET_VAL=8'hA5 ----
        rst8 = 1'b1; step();
        chk8("w8_reset", 8'hA5);

        rst8 = 1'b0; e8 = 1'b1; d8 = 8'h3C; step();
        chk8("w8_load", 8'h3C);

        e8 = 1'b0; d8 = 8'hFF; step();
        chk8("w8_hold", 8'h3C);
        step();
        chk8("w8_hold2", 8'h3C);

        e8 = 1'b1; d8 = 8'h5A; step();
        chk8("w8_load2", 8'h5A);

        rst8 = 1'b1; e8 = 1'b1; d8 = 8'hFF; step();
        chk8("w8_rst_priority", 8'hA5);
        rst8 = 1'b0;

        e8 = 1'b1; d8 = 8'h00; step();
        chk8("w8_load_zero", 8'h00);

`ifdef FPGA_DFFER_SET_EN
        e8 = 1'b0; d8 = 8'h12; set8 = 1'b1; step();
        chk8("w8_set_no_en", 8'hFF);

        set8 = 1'b0; e8 = 1'b1; d8 = 8'h00; step();
        chk8("w8_after_set", 8'h00);

        set8 = 1'b1; rst8 = 1'b1; step();
        chk8("w8_rst_over_set", 8'hA5);

        rst8 = 1'b0; set8 = 1'b1; e8 = 1'b1; d8 = 8'h0F; step();
        chk8("w8_set_over_en", 8'hFF);
        set8 = 1'b0;

        set1 = 1'b1; e1 = 1'b0; step();
        chk1("w1_set", 1'b1);
        set1 = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
